mem_block_copier: RTL and testbench

//   Bus-master stage directly upstream of the single-port Memory. On a start

---
 rtl/mem_block_copier_if.sv | 24 ++
 rtl/mem_block_copier.sv | 122 ++++++++++++
 tb/tb_mem_block_copier.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_block_copier_if.sv
// rtl/mem_block_copier_if.sv - command and memory-control signals of the block copier
interface mem_block_copier_if #(
    parameter int AW = 8
);
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic          mem_re;
    logic          mem_we;
    logic [AW-1:0] mem_addr;

    modport master (
        input  start, src_addr, dst_addr, len,
        output busy, done, mem_re, mem_we, mem_addr
    );

    modport slave (
        output start, src_addr, dst_addr, len,
        input  busy, done, mem_re, mem_we, mem_addr
    );
endinterface

// File: rtl/mem_block_copier.sv
// rtl/mem_block_copier.sv - word-by-word memory block copier on a shared tri-state bus
// Optional running checksum of copied words when CHECKSUM_EN is defined.
module mem_block_copier #(
    parameter int DW = 16,
    parameter int W  = 256,
    parameter int AW = $clog2(W)
) (
    input  logic              clock,
    input  logic              reset_L,
    mem_block_copier_if.master bus,
    inout  tri [DW-1:0]       mem_data
`ifdef CHECKSUM_EN
    ,
    output logic [DW-1:0]     checksum
`endif
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [AW:0] LEN_MAX = (AW+1)'(W);

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] src_q;
    logic [AW-1:0] dst_q;
    logic [AW:0]   len_q;
    logic [AW:0]   count;
    logic [DW-1:0] data_q;
    logic [AW:0]   len_clamped;
    logic          last_word;
    logic          drive;

    assign len_clamped = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
    assign last_word   = ((count + (AW+1)'(1)) == len_q);

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.mem_re   = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_addr = '0;
        drive        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = (len_clamped == '0) ? DONE : READ;
                end
            end
            READ: begin
                bus.busy     = 1'b1;
                bus.mem_re   = 1'b1;
                bus.mem_addr = src_q + count[AW-1:0];
                state_next   = WRITE;
            end
            WRITE: begin
                bus.busy     = 1'b1;
                bus.mem_we   = 1'b1;
                bus.mem_addr = dst_q + count[AW-1:0];
                drive        = 1'b1;
                state_next   = last_word ? DONE : READ;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Only WRITE drives the bus, so the Memory's read driver never collides with ours.
    assign mem_data = drive ? data_q : {DW{1'bz}};

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            count  <= '0;
            data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        src_q <= bus.src_addr;
                        dst_q <= bus.dst_addr;
                        len_q <= len_clamped;
                        count <= '0;
                    end
                end
                READ:    data_q <= mem_data;
                WRITE:   count  <= count + (AW+1)'(1);
                default: ;
            endcase
        end
    end

`ifdef CHECKSUM_EN
    logic [DW-1:0] sum_q;

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            sum_q <= '0;
        end else if (state == IDLE && bus.start) begin
            sum_q <= '0;
        end else if (state == READ) begin
            sum_q <= sum_q + mem_data;
        end
    end

    assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_mem_block_copier.sv
// tb/tb_mem_block_copier.sv - randomized self-checking bench for mem_block_copier
module tb_mem_block_copier;
    localparam int DW = 16;
    localparam int W  = 256;
    localparam int AW = 8;

    logic clock = 1'b0;
    logic reset_L = 1'b0;
    always #5 clock = ~clock;

    mem_block_copier_if #(.AW(AW)) bus_if();
    tri [DW-1:0] mem_data;
`ifdef CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    mem_block_copier #(.DW(DW), .W(W), .AW(AW)) dut (
        .clock    (clock),
        .reset_L  (reset_L),
        .bus      (bus_if.master),
        .mem_data (mem_data)
`ifdef CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    logic [DW-1:0] mem  [W];
    logic [DW-1:0] gold [W];
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [DW-1:0] load_data = '0;

    // Memory model: asynchronous read onto the bus, write at the edge; a write
    // coinciding with reset is dropped because the Memory shares the reset.
    assign mem_data = bus_if.mem_re ? mem[bus_if.mem_addr] : {DW{1'bz}};
    always @(posedge clock) begin
        if (load_en) mem[load_addr] <= load_data;
        else if (bus_if.mem_we && reset_L) mem[bus_if.mem_addr] <= mem_data;
    end

    int checks = 0;
    int errors = 0;
    int rd_total = 0;
    int wr_total = 0;
    int done_total = 0;
    logic [DW-1:0] last_cs = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (bus_if.mem_re) rd_total++;
        if (bus_if.mem_we) wr_total++;
        if (bus_if.done) done_total++;
        check_eq("re_we_exclusive", {31'b0, bus_if.mem_re & bus_if.mem_we}, 32'd0);
    end

    task automatic load_word(input int a, input logic [DW-1:0] v);
        @(negedge clock);
        load_en = 1'b1; load_addr = AW'(a); load_data = v;
        @(posedge clock);
        #1 load_en = 1'b0;
        gold[a] = v;
    endtask

    task automatic check_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < W; i++) if (mem[i] !== gold[i]) bad++;
        check_eq(tag, bad, 0);
    endtask

    task automatic run_copy(input int s, input int d, input int l, input bit poke);
        int lc;
        int cyc;
        int rd0, wr0, dn0;
        bit got;
        logic [DW-1:0] v;
        logic [DW-1:0] exp_sum;
        lc = (l > W) ? W : l;
        exp_sum = '0;
        for (int k = 0; k < lc; k++) begin
            v = gold[(s + k) % W];
            exp_sum = exp_sum + v;
            gold[(d + k) % W] = v;
        end
        @(negedge clock);
        bus_if.start = 1'b1; bus_if.src_addr = AW'(s); bus_if.dst_addr = AW'(d); bus_if.len = (AW+1)'(l);
        @(posedge clock);
        #1;
        bus_if.start = 1'b0;
        bus_if.src_addr = AW'($urandom); bus_if.dst_addr = AW'($urandom); bus_if.len = (AW+1)'($urandom);
        rd0 = rd_total; wr0 = wr_total; dn0 = done_total;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 2 * W + 20) begin
            @(negedge clock);
            cyc++;
            if (cyc == 1) check_eq("busy_first_cycle", {31'b0, bus_if.busy}, (lc != 0) ? 32'd1 : 32'd0);
            if (poke && cyc == 1) begin
                bus_if.start = 1'b1; bus_if.src_addr = AW'(s + 100); bus_if.dst_addr = AW'(d + 77); bus_if.len = 9'd5;
            end
            if (poke && cyc == 2) bus_if.start = 1'b0;
            if (bus_if.done) begin
                got = 1'b1;
`ifdef CHECKSUM_EN
                last_cs = checksum;
                check_eq("checksum", checksum, exp_sum);
`endif
            end
        end
        check_eq("done_latency", cyc, 2 * lc + 1);
        @(negedge clock);
        check_eq("done_one_cycle", {31'b0, bus_if.done}, 32'd0);
        check_eq("idle_busy", {31'b0, bus_if.busy}, 32'd0);
        check_eq("done_count", done_total - dn0, 1);
        check_eq("read_count", rd_total - rd0, lc);
        check_eq("write_count", wr_total - wr0, lc);
        check_mem("mem_contents");
    endtask

    initial begin
        int cyc;
        int dn0, wr0;
        bus_if.start = 1'b0; bus_if.src_addr = '0; bus_if.dst_addr = '0; bus_if.len = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_busy", {31'b0, bus_if.busy}, 32'd0);
        check_eq("rst_done", {31'b0, bus_if.done}, 32'd0);
        check_eq("rst_re", {31'b0, bus_if.mem_re}, 32'd0);
        check_eq("rst_we", {31'b0, bus_if.mem_we}, 32'd0);
        check_eq("rst_addr", {24'b0, bus_if.mem_addr}, 32'd0);
`ifdef CHECKSUM_EN
        check_eq("rst_checksum", {16'b0, checksum}, 32'd0);
`endif
        reset_L = 1'b1;

        for (int i = 0; i < W; i++) load_word(i, DW'($urandom));

        for (int i = 0; i < 4; i++) load_word(i, DW'(i + 1));
        run_copy(0, 8, 4, 1'b0);
        for (int i = 0; i < 4; i++) check_eq("basic_word", {16'b0, mem[8 + i]}, i + 1);

        run_copy(5, 9, 0, 1'b0);

        load_word(254, 16'hAAAA); load_word(255, 16'hBBBB);
        load_word(0, 16'hCCCC);   load_word(1, 16'hDDDD);
        run_copy(254, 1, 4, 1'b0);
        check_eq("wrap_m1", {16'b0, mem[1]}, 32'hAAAA);
        check_eq("wrap_m3", {16'b0, mem[3]}, 32'hCCCC);
        check_eq("wrap_m4_smear", {16'b0, mem[4]}, 32'hAAAA);

        for (int k = 0; k < 2; k++) gold[50 + k] = gold[40 + k];
        @(negedge clock);
        bus_if.start = 1'b1; bus_if.src_addr = 8'd40; bus_if.dst_addr = 8'd50; bus_if.len = 9'd6;
        @(posedge clock);
        #1 bus_if.start = 1'b0;
        dn0 = done_total; wr0 = wr_total;
        cyc = 0;
        while (cyc < 6) begin
            @(negedge clock);
            cyc++;
        end
        check_eq("abort_in_write", {31'b0, bus_if.mem_we}, 32'd1);
        check_eq("abort_addr", {24'b0, bus_if.mem_addr}, 32'd52);
        reset_L = 1'b0;
        @(negedge clock);
        check_eq("abort_busy", {31'b0, bus_if.busy}, 32'd0);
        check_eq("abort_re", {31'b0, bus_if.mem_re}, 32'd0);
        check_eq("abort_we", {31'b0, bus_if.mem_we}, 32'd0);
        check_eq("abort_addr_zero", {24'b0, bus_if.mem_addr}, 32'd0);
        reset_L = 1'b1;
        repeat (14) @(negedge clock);
        check_eq("abort_no_done", done_total - dn0, 0);
        check_eq("abort_writes", wr_total - wr0, 3);
        check_mem("abort_mem");

        run_copy(60, 70, 3, 1'b1);

        load_word(20, 16'hFFFF); load_word(21, 16'h0002);
        run_copy(20, 30, 2, 1'b0);
`ifdef CHECKSUM_EN
        check_eq("checksum_wrap", {16'b0, last_cs}, 32'h0001);
`endif

        run_copy(10, 200, W + 7, 1'b0);

        for (int t = 0; t < 24; t++) begin
            int l;
            l = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, W + 8));
            run_copy(int'($urandom_range(0, W - 1)), int'($urandom_range(0, W - 1)), l, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
